ws_strip_streamer: RTL and testbench
====================================

Name: ws_strip_streamer

Overview:
- Next-generation WS2812-family strip driver. Streams a whole frame of NUM_LEDS pixels from an external synchronous pixel RAM onto a single-wire DO line, then holds the latch/reset gap.
- Generalised over:
  - strip length;
  - 24-bit (RGB) or 32-bit (RGBW) pixels;
  - cycle-exact bit timing;
  - runtime colour order.
- Adds a start/busy/done handshake and a free-running repeat mode.
- Sits between the frame-buffer RAM and the strip output pin.

Parameters:
- NUM_LEDS, 10: pixels per frame; must be >= 1.
- BITS_PER_LED, 24: 24 (RGB) or 32 (RGBW); any other value is a configuration error.
- T0H_CYC, 20: clk cycles DO is high for a '0' bit.
- T1H_CYC, 40: clk cycles DO is high for a '1' bit.
- BIT_CYC, 61: total clk cycles per bit. Must satisfy T0H_CYC < T1H_CYC < BIT_CYC.
- RESET_CYC, 2500: clk cycles DO is held low after the last bit.
- AW, max(1,$clog2(NUM_LEDS)): pixel address width (derived).

Ports:
- clk  in  1  system clock; all timing is counted in clk cycles.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- repeat_en  in  1  when high at end of LATCH, the next frame starts automatically.
- color_order  in  2  wire order: 0=GRB, 1=RGB, 2=BRG, 3=raw (as stored). Latched at frame start.
- pix_rd  out  1  one-cycle read strobe to the pixel RAM.
- pix_addr  out  AW  pixel index for pix_rd.
- pix_data  in  BITS_PER_LED  RAM read data, valid exactly 1 cycle after pix_rd. Stored as {R,G,B} (24) or {W,R,G,B} (32).
- DO  out  1  strip data line.
- busy  out  1  high from the cycle after start is accepted until frame_done.
- sending_data  out  1  high while pixel bits are on DO (SEND only).
- frame_done  out  1  one-cycle pulse at the end of LATCH.

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE;
  - DO, busy, sending_data, frame_done and pix_rd = 0;
  - pix_addr = 0;
  - all counters = 0.
  - Reset mid-frame aborts the frame with no latch gap and no frame_done.
- States: IDLE, FETCH, SEND, LATCH. All outputs are registered.
- IDLE:
  - If start=1 at edge E0: latch color_order; busy=1; pix_rd=1 and pix_addr=0 during the cycle after E0; go to FETCH.
  - If start=0: DO=0.
- FETCH (1 cycle):
  - Capture pix_data at E2.
  - Load the shift register with the reordered word; pix_index=0; go to SEND.
  - DO rises in the cycle after E2, i.e. the first high cycle is 2 cycles after start is sampled.
- Reorder:
  - order 0 puts {G,R,B} on the wire; order 1 {R,G,B}; order 2 {B,R,G}; order 3 sends the stored word unchanged.
  - For 32-bit pixels, W is always sent last (except order 3).
  - Bits go out MSB first.
- SEND, per bit:
  - bit_cnt counts 0..BIT_CYC-1.
  - DO=1 while bit_cnt < (bit ? T1H_CYC : T0H_CYC), else 0.
  - At bit_cnt=BIT_CYC-1, shift to the next bit.
  - No extra cycles between bits or between pixels.
- Prefetch:
  - In the first cycle of bit 0 of pixel n, if n+1 < NUM_LEDS: pix_rd=1, pix_addr=n+1.
  - Capture into the next_pix register one cycle later.
  - At the end of the last bit of pixel n, load next_pix into the shift register.
  - There is never more than one outstanding read.
- After the last bit of pixel NUM_LEDS-1:
  - sending_data=0, DO=0; go to LATCH.
  - sending_data is high exactly NUM_LEDS*BITS_PER_LED*BIT_CYC cycles per frame.
- LATCH:
  - Hold DO=0 for exactly RESET_CYC cycles.
  - In the cycle after the gap ends: frame_done=1 for 1 cycle.
  - If repeat_en=1 in that cycle: re-latch color_order and issue a read of addr 0 (as in IDLE), busy stays high, go to FETCH.
  - Otherwise busy=0 and go to IDLE.
- start while busy: ignored; it is not queued.
- start in the same cycle as frame_done with repeat_en=0: ignored; the next start is accepted from IDLE one cycle later.
- NUM_LEDS=1: no prefetch read is ever issued.
- pix_addr holds its last value when pix_rd=0.
- Counter widths:
  - bit_cnt: $clog2(BIT_CYC);
  - gap counter: $clog2(RESET_CYC+1);
  - bit index: $clog2(BITS_PER_LED).
- No wrap-around occurs within a frame.

Test Plan:
- Reset, then start pulse with NUM_LEDS=2, 24-bit, order 0, RAM[0]=0xFF0000, RAM[1]=0x0000FF:
  - wire bits are 00000000 11111111 00000000 then 00000000 00000000 11111111;
  - '1' bits measure 40 high / 21 low, '0' bits 20 high / 41 low.
- Same frame:
  - pix_rd pulses at addr 0 (cycle after start) and addr 1 (first cycle of pixel 0);
  - first DO rise is 2 cycles after start;
  - sending_data high 2*24*61=2928 cycles;
  - DO low 2500 cycles, then frame_done for 1 cycle and busy falls.
- BITS_PER_LED=32, order 1, RAM[0]=0x11223344 -> wire = 0x22,0x33,0x44,0x11 MSB first. With order 3 -> 0x11,0x22,0x33,0x44.
- repeat_en=1 held:
  - second frame's pix_rd(addr 0) occurs in the frame_done cycle;
  - busy never drops;
  - a start pulse mid-frame has no effect on timing.
- Assert rst midway through pixel 1 bit 5 -> DO, busy, sending_data = 0 immediately, no frame_done. A start after deassert produces a complete, correct frame.

Source files
------------

// File: rtl/ws_strip_streamer.sv
// ws_strip_streamer: streams one frame of pixels from a synchronous pixel RAM
// onto a WS2812-style single-wire line, then holds the latch gap low.
// One-deep prefetch keeps pixels back-to-back with no idle cycles on the wire.
module ws_strip_streamer #(
  parameter int NUM_LEDS     = 10,
  parameter int BITS_PER_LED = 24,
  parameter int T0H_CYC      = 20,
  parameter int T1H_CYC      = 40,
  parameter int BIT_CYC      = 61,
  parameter int RESET_CYC    = 2500,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    repeat_en,
  input  logic [1:0]              color_order,
  output logic                    pix_rd,
  output logic [AW-1:0]           pix_addr,
  input  logic [BITS_PER_LED-1:0] pix_data,
  output logic                    DO,
  output logic                    busy,
  output logic                    sending_data,
  output logic                    frame_done
);

  localparam int CW = $clog2(BIT_CYC);
  localparam int GW = $clog2(RESET_CYC + 1);
  localparam int IW = $clog2(BITS_PER_LED);

  localparam logic [CW-1:0] T0H_L    = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_L    = CW'(T1H_CYC);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_LED - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(RESET_CYC - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(NUM_LEDS - 1);

  if (!(BITS_PER_LED == 24 || BITS_PER_LED == 32)) begin : g_bad_bits
    $error("ws_strip_streamer: BITS_PER_LED must be 24 or 32");
  end
  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
    $error("ws_strip_streamer: need 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (NUM_LEDS < 1 || RESET_CYC < 1) begin : g_bad_size
    $error("ws_strip_streamer: NUM_LEDS and RESET_CYC must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

  state_t                  state_q;
  logic                    fetch_wait_q;  // first FETCH cycle: RAM still reading
  logic [1:0]              order_q;
  logic [BITS_PER_LED-1:0] shift_q;
  logic [BITS_PER_LED-1:0] next_pix_q;
  logic                    cap_q;         // prefetched word arrives this cycle
  logic [CW-1:0]           bit_cnt_q;
  logic [IW-1:0]           bit_idx_q;
  logic [AW-1:0]           pix_idx_q;
  logic [GW-1:0]           gap_cnt_q;

  // Stored word is {R,G,B} or {W,R,G,B}; produce the wire order, W always last.
  function automatic logic [BITS_PER_LED-1:0] reorder(
    input logic [BITS_PER_LED-1:0] w,
    input logic [1:0]              ord
  );
    logic [31:0] wp;
    logic [31:0] o;
    logic [23:0] t;
    wp = 32'(w);
    case (ord)
      2'd0:    t = {wp[15:8], wp[23:16], wp[7:0]};
      2'd2:    t = {wp[7:0], wp[23:16], wp[15:8]};
      default: t = wp[23:0];
    endcase
    if (BITS_PER_LED == 32) o = {t, wp[31:24]};
    else                    o = {8'h00, t};
    if (ord == 2'd3) o = wp;
    return o[BITS_PER_LED-1:0];
  endfunction

  // Bit-timing helpers derived from the current bit position.
  logic [CW-1:0] bit_cnt_inc;
  logic [CW-1:0] hi_len;
  logic          last_cnt;
  logic          last_bit;
  logic          last_pix;
  logic          more_after_next;
  logic [AW-1:0] addr_after_next;

  assign bit_cnt_inc     = bit_cnt_q + 1'b1;
  assign hi_len          = shift_q[BITS_PER_LED-1] ? T1H_L : T0H_L;
  assign last_cnt        = (bit_cnt_q == BIT_LAST);
  assign last_bit        = (bit_idx_q == IDX_LAST);
  assign last_pix        = (pix_idx_q == PIX_LAST);
  assign more_after_next = (int'(pix_idx_q) + 2) < NUM_LEDS;
  assign addr_after_next = AW'(int'(pix_idx_q) + 2);

  // Frame sequencer: every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_wait_q <= 1'b0;
      order_q      <= 2'd0;
      shift_q      <= '0;
      next_pix_q   <= '0;
      cap_q        <= 1'b0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      pix_idx_q    <= '0;
      gap_cnt_q    <= '0;
      pix_rd       <= 1'b0;
      pix_addr     <= '0;
      DO           <= 1'b0;
      busy         <= 1'b0;
      sending_data <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the values registered at the previous edge regardless of statement order.
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          DO <= 1'b0;
          // A start coinciding with frame_done is dropped, not queued.
          if (start && !frame_done) begin
            order_q      <= color_order;
            busy         <= 1'b1;
            pix_rd       <= 1'b1;
            pix_addr     <= '0;
            fetch_wait_q <= 1'b1;
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_wait_q) begin
            fetch_wait_q <= 1'b0;
          end else begin
            shift_q      <= reorder(pix_data, order_q);
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            pix_idx_q    <= '0;
            cap_q        <= 1'b0;
            DO           <= 1'b1;
            sending_data <= 1'b1;
            state_q      <= S_SEND;
            if (NUM_LEDS > 1) begin
              pix_rd   <= 1'b1;
              pix_addr <= AW'(1);
            end
          end
        end
        S_SEND: begin
          cap_q <= pix_rd;
          if (cap_q) next_pix_q <= pix_data;
          if (!last_cnt) begin
            bit_cnt_q <= bit_cnt_inc;
            DO        <= (bit_cnt_inc < hi_len);
          end else if (!last_bit) begin
            bit_cnt_q <= '0;
            bit_idx_q <= bit_idx_q + 1'b1;
            shift_q   <= shift_q << 1;
            DO        <= 1'b1;
          end else if (!last_pix) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            pix_idx_q <= pix_idx_q + 1'b1;
            shift_q   <= reorder(next_pix_q, order_q);
            DO        <= 1'b1;
            if (more_after_next) begin
              pix_rd   <= 1'b1;
              pix_addr <= addr_after_next;
            end
          end else begin
            DO           <= 1'b0;
            sending_data <= 1'b0;
            gap_cnt_q    <= '0;
            state_q      <= S_LATCH;
          end
        end
        S_LATCH: begin
          DO <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            frame_done <= 1'b1;
            if (repeat_en) begin
              order_q      <= color_order;
              pix_rd       <= 1'b1;
              pix_addr     <= '0;
              fetch_wait_q <= 1'b1;
              state_q      <= S_FETCH;
            end else begin
              busy    <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws_strip_streamer.sv
// Directed bench for ws_strip_streamer: decodes DO per bit, checks bit timing,
// fetch/prefetch strobes, sending window, latch gap and the handshake.
module tb_ws_strip_streamer;

  localparam int BITC = 61;

  logic clk;
  logic rst;

  // Instance 0: two RGB pixels, default timing.
  logic        start0, repeat_en0, pix_rd0, do0, busy0, send0, fd0;
  logic [1:0]  color_order0;
  logic [0:0]  pix_addr0;
  logic [23:0] pix_data0;
  logic [23:0] mem0 [2];

  // Instance 1: one RGBW pixel, short latch gap.
  logic        start1, repeat_en1, pix_rd1, do1, busy1, send1, fd1;
  logic [1:0]  color_order1;
  logic [0:0]  pix_addr1;
  logic [31:0] pix_data1;
  logic [31:0] mem1 [2];

  int checks = 0;
  int errors = 0;
  int rd_cnt   [2] = '{0, 0};
  int send_cnt [2] = '{0, 0};
  int fd_cnt   [2] = '{0, 0};
  int busy_lo  [2] = '{0, 0};

  ws_strip_streamer #(
    .NUM_LEDS(2), .BITS_PER_LED(24), .T0H_CYC(20), .T1H_CYC(40),
    .BIT_CYC(61), .RESET_CYC(2500)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .repeat_en(repeat_en0),
    .color_order(color_order0), .pix_rd(pix_rd0), .pix_addr(pix_addr0),
    .pix_data(pix_data0), .DO(do0), .busy(busy0), .sending_data(send0),
    .frame_done(fd0)
  );

  ws_strip_streamer #(
    .NUM_LEDS(1), .BITS_PER_LED(32), .T0H_CYC(20), .T1H_CYC(40),
    .BIT_CYC(61), .RESET_CYC(100)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .repeat_en(repeat_en1),
    .color_order(color_order1), .pix_rd(pix_rd1), .pix_addr(pix_addr1),
    .pix_data(pix_data1), .DO(do1), .busy(busy1), .sending_data(send1),
    .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel RAMs: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (pix_rd0) pix_data0 <= mem0[pix_addr0];
    if (pix_rd1) pix_data1 <= mem1[pix_addr1];
  end

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (pix_rd0) rd_cnt[0]++;
    if (pix_rd1) rd_cnt[1]++;
    if (send0) send_cnt[0]++;
    if (send1) send_cnt[1]++;
    if (fd0) fd_cnt[0]++;
    if (fd1) fd_cnt[1]++;
    if (!busy0) busy_lo[0]++;
    if (!busy1) busy_lo[1]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  function automatic int f_do(input bit s);   return s ? int'(do1)    : int'(do0);    endfunction
  function automatic int f_rd(input bit s);   return s ? int'(pix_rd1) : int'(pix_rd0); endfunction
  function automatic int f_addr(input bit s); return s ? int'(pix_addr1) : int'(pix_addr0); endfunction
  function automatic int f_busy(input bit s); return s ? int'(busy1)  : int'(busy0);  endfunction
  function automatic int f_send(input bit s); return s ? int'(send1)  : int'(send0);  endfunction
  function automatic int f_fd(input bit s);   return s ? int'(fd1)    : int'(fd0);    endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point; the start is seen at the next edge.
  task automatic pulse_start(input bit s);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    step();
    if (s) start1 = 1'b0; else start0 = 1'b0;
  endtask

  // Decode nbits from DO starting at cycle 0 of the first bit.
  task automatic recv_word(input bit s, input int nbits, input int exp, input string tag);
    int got = 0;
    int shape_err = 0;
    for (int b = 0; b < nbits; b++) begin
      int hi = 0;
      bit seen_low = 1'b0;
      int eb = (exp >> (nbits - 1 - b)) & 1;
      for (int c = 0; c < BITC; c++) begin
        if (f_do(s) == 1) begin
          hi++;
          if (seen_low) shape_err++;
        end else begin
          seen_low = 1'b1;
        end
        step();
      end
      got = (got << 1) | ((hi > 30) ? 1 : 0);
      check($sformatf("%s_hi_b%0d", tag, b), hi, (eb != 0) ? 40 : 20);
    end
    check({tag, "_word"}, got, exp);
    check({tag, "_shape"}, shape_err, 0);
  endtask

  // Starts in the cycle that should carry the addr-0 read; ends in the
  // frame_done cycle.
  task automatic run_frame(input bit s, input int npix, input int nbits,
                           input int e0, input int e1, input int gap,
                           input int end_busy, input string tag);
    int rd_base = rd_cnt[s];
    int sd_base = send_cnt[s];
    int n = 0;
    int lo_err = 0;
    check({tag, "_rd0"}, f_rd(s), 1);
    check({tag, "_addr0"}, f_addr(s), 0);
    check({tag, "_busy"}, f_busy(s), 1);
    check({tag, "_do_fetch"}, f_do(s), 0);
    step();
    check({tag, "_rd_off"}, f_rd(s), 0);
    check({tag, "_do_wait"}, f_do(s), 0);
    check({tag, "_send_wait"}, f_send(s), 0);
    step();
    check({tag, "_prefetch"}, f_rd(s), (npix > 1) ? 1 : 0);
    if (npix > 1) check({tag, "_prefetch_addr"}, f_addr(s), 1);
    recv_word(s, nbits, e0, {tag, "_p0"});
    if (npix > 1) begin
      check({tag, "_no_extra_rd"}, f_rd(s), 0);
      recv_word(s, nbits, e1, {tag, "_p1"});
    end
    check({tag, "_send_end"}, f_send(s), 0);
    while (f_fd(s) == 0 && n < gap + 20) begin
      if (f_do(s) != 0) lo_err++;
      n++;
      step();
    end
    check({tag, "_gap_len"}, n, gap);
    check({tag, "_gap_low"}, lo_err, 0);
    check({tag, "_frame_done"}, f_fd(s), 1);
    check({tag, "_busy_end"}, f_busy(s), end_busy);
    check({tag, "_send_cycles"}, send_cnt[s] - sd_base, npix * nbits * BITC);
    check({tag, "_rd_count"}, rd_cnt[s] - rd_base, npix);
  endtask

  initial begin
    int bl;
    int fd_base;
    rst = 1'b1;
    start0 = 1'b0; repeat_en0 = 1'b0; color_order0 = 2'd0;
    start1 = 1'b0; repeat_en1 = 1'b0; color_order1 = 2'd0;
    mem0[0] = 24'hFF0000; mem0[1] = 24'h0000FF;
    mem1[0] = 32'h11223344; mem1[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do", int'(do0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_send", int'(send0), 0);
    check("rst_fd", int'(fd0), 0);
    check("rst_rd", int'(pix_rd0), 0);
    check("rst_addr", int'(pix_addr0), 0);
    check("rst_do1", int'(do1), 0);
    @(negedge clk) rst = 1'b0;
    step(); step();

    // Frame A: GRB order, red then blue.
    pulse_start(0);
    run_frame(0, 2, 24, 'h00FF00, 'h0000FF, 2500, 0, "A");

    // Start raised in the frame_done cycle is ignored, accepted one cycle later.
    mem0[0] = 24'h123456; mem0[1] = 24'hA5C30F;
    color_order0 = 2'd2;
    start0 = 1'b1;
    step();
    check("start_at_done_busy", int'(busy0), 0);
    check("start_at_done_rd", int'(pix_rd0), 0);
    step();
    start0 = 1'b0;
    color_order0 = 2'd1;  // must not affect the frame in flight
    run_frame(0, 2, 24, 'h561234, 'h0FA5C3, 2500, 0, "B");
    step();
    check("done_one_cycle", int'(fd0), 0);

    // Repeat mode: R1 uses RGB, R2 picks up GRB re-latched at frame_done.
    repeat_en0 = 1'b1;
    pulse_start(0);
    bl = busy_lo[0];
    fork
      run_frame(0, 2, 24, 'h123456, 'hA5C30F, 2500, 1, "R1");
      begin
        repeat (200) step();
        color_order0 = 2'd0;
      end
    join
    fork
      run_frame(0, 2, 24, 'h341256, 'hC3A50F, 2500, 0, "R2");
      begin
        repeat (1500) step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat_en0 = 1'b0;
      end
    join
    check("repeat_busy_never_low", busy_lo[0] - bl, 0);
    step();

    // Reset in the middle of pixel 1, bit 5.
    color_order0 = 2'd3;
    pulse_start(0);
    fd_base = fd_cnt[0];
    repeat (2 + 29 * BITC + 30) step();
    check("mid_send_active", int'(send0), 1);
    check("mid_do_high", int'(do0), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_do", int'(do0), 0);
    check("arst_busy", int'(busy0), 0);
    check("arst_send", int'(send0), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3000) step();
    check("arst_no_frame_done", fd_cnt[0] - fd_base, 0);
    pulse_start(0);
    run_frame(0, 2, 24, 'h123456, 'hA5C30F, 2500, 0, "P");

    // RGBW, single pixel: no prefetch, W last for RGB, raw for order 3.
    color_order1 = 2'd1;
    pulse_start(1);
    run_frame(1, 1, 32, 'h22334411, 0, 100, 0, "W1");
    step();
    color_order1 = 2'd3;
    pulse_start(1);
    run_frame(1, 1, 32, 'h11223344, 0, 100, 0, "W3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
